// File: rtl/cpu_control_if.sv
// Memory handshake between the control unit and the memory system:
// request/ready plus the instruction word presented on the data bus.
interface cpu_control_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] instr_in;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;

  modport master (
    input  instr_in,
    input  mem_ready,
    output mem_req,
    output mem_we
  );

  modport slave (
    output instr_in,
    output mem_ready,
    input  mem_req,
    input  mem_we
  );
endinterface

// File: rtl/cpu_control.sv
// Multi-cycle control unit: owns the instruction register and sequences the
// register/ALU/PC datapath through fetch, decode, execute, memory and writeback.
module cpu_control #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  cpu_control_if.master    mem,
  output logic             pc_reset,
  output logic             increment,
  output logic             fetch,
  output logic             wrAdd,
  output logic             wrData,
  output logic             regEn,
  output logic             store_en,
  output logic             store_PC,
  output logic             Branch_En,
  output logic             DataBus_En,
  output logic             pc_load,
  output logic [5:0]       opcode,
  output logic [4:0]       oppA,
  output logic [4:0]       oppB,
  output logic [WIDTH-1:0] literal,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_F_ADDR,
    S_F_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_BR_EXEC,
    S_BR_LOAD,
    S_M_ADDR,
    S_S_DATA,
    S_M_WAIT,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_LOAD  = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_PASS  = 6'b110000;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ir;
  logic             ir_load;

  logic [5:0]       ir_op;
  logic [4:0]       ir_ra;
  logic [4:0]       ir_rb;
  logic [4:0]       ir_rc;
  logic [WIDTH-1:0] ir_imm;
  logic             is_load;
  logic             is_store;
  logic             is_halt;

  assign ir_op    = ir[31:26];
  assign ir_ra    = ir[25:21];
  assign ir_rb    = ir[20:16];
  assign ir_rc    = ir[15:11];
  assign ir_imm   = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign is_load  = (ir_op == OP_LOAD);
  assign is_store = (ir_op == OP_STORE);
  assign is_halt  = (ir_op == OP_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_F_ADDR;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (ir_load) begin
        ir <= mem.instr_in;
      end
    end
  end

  // Outputs are gated by reset so an access in flight is dropped in the reset cycle itself.
  always_comb begin
    state_next  = state;
    ir_load     = 1'b0;
    pc_reset    = 1'b0;
    increment   = 1'b0;
    fetch       = 1'b0;
    wrAdd       = 1'b0;
    wrData      = 1'b0;
    regEn       = 1'b0;
    store_en    = 1'b0;
    store_PC    = 1'b0;
    Branch_En   = 1'b0;
    DataBus_En  = 1'b0;
    pc_load     = 1'b0;
    opcode      = '0;
    oppA        = '0;
    oppB        = '0;
    literal     = '0;
    halted      = 1'b0;
    illegal     = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;

    if (!reset) begin
      pc_reset = 1'b1;
    end else begin
      if (state != S_F_ADDR && state != S_F_WAIT) begin
        opcode  = ir_op;
        oppA    = ir_ra;
        oppB    = ir_rb;
        literal = ir_imm;
      end

      case (state)
        S_F_ADDR: begin
          fetch      = 1'b1;
          wrAdd      = 1'b1;
          state_next = S_F_WAIT;
        end
        S_F_WAIT: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_load    = 1'b1;
            increment  = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_halt) begin
            state_next = S_HALT;
          end else begin
            case (ir_op[5:4])
              2'b00, 2'b11: state_next = S_EXEC;
              2'b01:        state_next = S_BR_EXEC;
              default: begin
                if (is_load || is_store) begin
                  state_next = S_M_ADDR;
                end else begin
                  illegal    = 1'b1;
                  state_next = S_F_ADDR;
                end
              end
            endcase
          end
        end
        S_EXEC: begin
          wrData     = 1'b1;
          state_next = S_WB;
        end
        S_WB: begin
          regEn      = 1'b1;
          state_next = S_F_ADDR;
        end
        S_BR_EXEC: begin
          Branch_En  = 1'b1;
          wrData     = 1'b1;
          state_next = S_BR_LOAD;
        end
        S_BR_LOAD: begin
          pc_load    = 1'b1;
          state_next = S_F_ADDR;
        end
        S_M_ADDR: begin
          opcode     = OP_ADD;
          wrAdd      = 1'b1;
          state_next = is_store ? S_S_DATA : S_M_WAIT;
        end
        S_S_DATA: begin
          // Route rC through the ALU unchanged so dataR holds the store value.
          opcode     = OP_PASS;
          oppA       = ir_rc;
          literal    = '0;
          wrData     = 1'b1;
          state_next = S_M_WAIT;
        end
        S_M_WAIT: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = is_store;
          DataBus_En  = is_store;
          if (mem.mem_ready) begin
            store_en   = is_load;
            regEn      = is_load;
            state_next = S_F_ADDR;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_next = S_F_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: steps each instruction class cycle by cycle
// and compares every strobe plus the decoded fields against hand-derived values.
module tb_cpu_control;

  localparam logic [14:0] B_PCRST  = 15'h4000;
  localparam logic [14:0] B_INC    = 15'h2000;
  localparam logic [14:0] B_FETCH  = 15'h1000;
  localparam logic [14:0] B_WRADD  = 15'h0800;
  localparam logic [14:0] B_WRDATA = 15'h0400;
  localparam logic [14:0] B_REGEN  = 15'h0200;
  localparam logic [14:0] B_STEN   = 15'h0100;
  localparam logic [14:0] B_STPC   = 15'h0080;
  localparam logic [14:0] B_BREN   = 15'h0040;
  localparam logic [14:0] B_DBEN   = 15'h0020;
  localparam logic [14:0] B_PCLD   = 15'h0010;
  localparam logic [14:0] B_REQ    = 15'h0008;
  localparam logic [14:0] B_WE     = 15'h0004;
  localparam logic [14:0] B_HALT   = 15'h0002;
  localparam logic [14:0] B_ILL    = 15'h0001;
  localparam logic [14:0] F_S      = B_FETCH | B_WRADD;

  logic        clk;
  logic        reset;
  logic        pc_reset, increment, fetch, wrAdd, wrData, regEn, store_en, store_PC;
  logic        Branch_En, DataBus_En, pc_load, halted, illegal;
  logic [5:0]  opcode;
  logic [4:0]  oppA, oppB;
  logic [31:0] literal;
  logic [14:0] strobes;
  int          check_count;
  int          pass_count;

  cpu_control_if #(.WIDTH(32)) mem_bus ();

  cpu_control #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem_bus),
    .pc_reset   (pc_reset),
    .increment  (increment),
    .fetch      (fetch),
    .wrAdd      (wrAdd),
    .wrData     (wrData),
    .regEn      (regEn),
    .store_en   (store_en),
    .store_PC   (store_PC),
    .Branch_En  (Branch_En),
    .DataBus_En (DataBus_En),
    .pc_load    (pc_load),
    .opcode     (opcode),
    .oppA       (oppA),
    .oppB       (oppB),
    .literal    (literal),
    .halted     (halted),
    .illegal    (illegal)
  );

  assign strobes = {pc_reset, increment, fetch, wrAdd, wrData, regEn, store_en, store_PC,
                    Branch_En, DataBus_En, pc_load, mem_bus.mem_req, mem_bus.mem_we,
                    halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_bus.instr_in = 32'h0022_0000;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_bus.mem_ready = 1'b1;
      #1;
      check_count++;
      if (strobes !== B_PCRST)
        $display("[TB] FAIL reset strobes cycle %0d: got %h expected %h", i + 1, strobes, B_PCRST);
      else pass_count++;
      check_count++;
      if ({opcode, oppA, oppB, literal} !== 48'h0)
        $display("[TB] FAIL reset fields cycle %0d: got %h expected 0", i + 1, {opcode, oppA, oppB, literal});
      else pass_count++;
    end
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_alu_reg();
    logic [14:0] exp_s [5];
    bit          rdy [5];
    exp_s = '{F_S, B_REQ | B_INC, 15'h0, B_WRDATA, B_REGEN};
    rdy   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mem_bus.instr_in = 32'h0022_0000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL alu_reg strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
      if (i >= 2) begin
        check_count++;
        if ({opcode, oppA, oppB} !== {6'd0, 5'd1, 5'd2})
          $display("[TB] FAIL alu_reg fields cycle %0d: got %h expected %h", i + 1,
                   {opcode, oppA, oppB}, {6'd0, 5'd1, 5'd2});
        else pass_count++;
      end
    end
    next_cycle();
  endtask

  task automatic test_alu_literal();
    logic [14:0] exp_s [6];
    bit          rdy [6];
    exp_s = '{F_S, B_REQ, B_REQ | B_INC, 15'h0, B_WRDATA, B_REGEN};
    rdy   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mem_bus.instr_in = 32'hC4A0_8001;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL alu_lit strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
      if (i == 3) begin
        check_count++;
        if ({opcode, oppA, literal} !== {6'h31, 5'd5, 32'hFFFF_8001})
          $display("[TB] FAIL alu_lit fields: got %h expected %h",
                   {opcode, oppA, literal}, {6'h31, 5'd5, 32'hFFFF_8001});
        else pass_count++;
      end
    end
    next_cycle();
  endtask

  // mem_ready is held high in DECODE and M_ADDR, where it must have no effect.
  task automatic test_load();
    logic [14:0] exp_s [7];
    bit          rdy [7];
    exp_s = '{F_S, B_REQ | B_INC, 15'h0, B_WRADD, B_REQ, B_REQ, B_REQ | B_STEN | B_REGEN};
    rdy   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    mem_bus.instr_in = 32'h80C7_0000;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL load strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
      if (i == 2) begin
        check_count++;
        if (opcode !== 6'h20)
          $display("[TB] FAIL load decode opcode: got %h expected 20", opcode);
        else pass_count++;
      end
      if (i == 3) begin
        check_count++;
        if ({opcode, oppA, oppB} !== {6'd0, 5'd6, 5'd7})
          $display("[TB] FAIL load m_addr fields: got %h expected %h",
                   {opcode, oppA, oppB}, {6'd0, 5'd6, 5'd7});
        else pass_count++;
      end
    end
    next_cycle();
  endtask

  task automatic test_store();
    logic [14:0] exp_s [6];
    bit          rdy [6];
    exp_s = '{F_S, B_REQ | B_INC, 15'h0, B_WRADD, B_WRDATA, B_REQ | B_WE | B_DBEN};
    rdy   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    mem_bus.instr_in = 32'h8464_2800;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL store strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
      if (i == 3) begin
        check_count++;
        if ({opcode, oppA, oppB} !== {6'd0, 5'd3, 5'd4})
          $display("[TB] FAIL store m_addr fields: got %h expected %h",
                   {opcode, oppA, oppB}, {6'd0, 5'd3, 5'd4});
        else pass_count++;
      end
      if (i == 4) begin
        check_count++;
        if ({opcode, oppA, literal} !== {6'h30, 5'd5, 32'h0})
          $display("[TB] FAIL store s_data fields: got %h expected %h",
                   {opcode, oppA, literal}, {6'h30, 5'd5, 32'h0});
        else pass_count++;
      end
    end
    next_cycle();
  endtask

  task automatic test_branch();
    logic [14:0] exp_s [5];
    bit          rdy [5];
    exp_s = '{F_S, B_REQ | B_INC, 15'h0, B_BREN | B_WRDATA, B_PCLD};
    rdy   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mem_bus.instr_in = 32'h4000_FFFE;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL branch strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
      if (i >= 2) begin
        check_count++;
        if ({opcode, literal} !== {6'h10, 32'hFFFF_FFFE})
          $display("[TB] FAIL branch fields cycle %0d: got %h expected %h", i + 1,
                   {opcode, literal}, {6'h10, 32'hFFFF_FFFE});
        else pass_count++;
      end
    end
    next_cycle();
  endtask

  task automatic test_illegal();
    logic [14:0] exp_s [3];
    bit          rdy [3];
    exp_s = '{F_S, B_REQ | B_INC, B_ILL};
    rdy   = '{1'b0, 1'b1, 1'b0};
    mem_bus.instr_in = 32'h8800_0000;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL illegal strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    logic [14:0] exp_s [4];
    bit          rdy [4];
    bit          rst [4];
    exp_s = '{F_S, B_REQ, B_PCRST, F_S};
    rdy   = '{1'b0, 1'b0, 1'b1, 1'b0};
    rst   = '{1'b1, 1'b1, 1'b0, 1'b1};
    mem_bus.instr_in = 32'h0022_0000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      reset = rst[i];
      mem_bus.mem_ready = rdy[i];
      #1;
      check_count++;
      if (strobes !== exp_s[i])
        $display("[TB] FAIL reset_mid_wait strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_s[i]);
      else pass_count++;
    end
  endtask

  task automatic test_halt();
    logic [14:0] exp_v;
    mem_bus.instr_in = 32'hFC00_0000;
    for (int i = 0; i < 23; i++) begin
      if (i > 0) next_cycle();
      mem_bus.mem_ready = (i == 1) ? 1'b1 : ((i > 2) ? i[0] : 1'b0);
      exp_v = (i == 0) ? F_S : (i == 1) ? (B_REQ | B_INC) : (i == 2) ? 15'h0 : B_HALT;
      #1;
      check_count++;
      if (strobes !== exp_v)
        $display("[TB] FAIL halt strobes cycle %0d: got %h expected %h", i + 1, strobes, exp_v);
      else pass_count++;
    end
    next_cycle();
    reset = 1'b0;
    #1;
    check_count++;
    if (strobes !== B_PCRST)
      $display("[TB] FAIL halt reset strobes: got %h expected %h", strobes, B_PCRST);
    else pass_count++;
    next_cycle();
    reset = 1'b1;
    mem_bus.mem_ready = 1'b0;
    #1;
    check_count++;
    if (strobes !== F_S)
      $display("[TB] FAIL halt exit strobes: got %h expected %h", strobes, F_S);
    else pass_count++;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset = 1'b0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.instr_in  = 32'h0;
    test_reset();
    test_alu_reg();
    test_alu_literal();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_reset_mid_wait();
    test_halt();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
